// File: rtl/game_fsm_ctrl.sv
// game_fsm_ctrl
//   Game-state sequencer for the snake game. It runs the RESTART/START/PLAY/DIE
//   flow and adds multiple lives with a respawn phase, a pause mode, a WIN state
//   at a configurable packed-BCD score, and rising-edge detection on the keys.
//   Every output is registered.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   hitwall    snake head hit wall (level, sampled in PLAY)
//   hitbody    snake head hit body (level, sampled in PLAY)
//   key        start/restart button (level, rising edge used)
//   pause_key  pause toggle button (level, rising edge used)
//   point      current score, 4-digit packed BCD
//   status     state code: 0 RESTART, 1 START, 2 PLAY, 3 DIE, 4 PAUSE,
//              5 RESPAWN, 6 WIN
//   die        snake visible (1) / blanked (0)
//   restart    high while in RESTART
//   score_flag high while in DIE or WIN
//   lives      remaining lives
module game_fsm_ctrl #(
  parameter int unsigned RESTART_CYC = 21,
  parameter int unsigned BLINK_CYC   = 25_000_000,
  parameter int unsigned BLINK_NUM   = 6,
  parameter int unsigned HOLD_CYC    = 200_000_000,
  parameter int unsigned RESPAWN_CYC = 50_000_000,
  parameter int unsigned LIFE_W      = 2,
  parameter int unsigned LIVES       = 3,
  parameter logic [15:0] WIN_POINT   = 16'h0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hitwall,
  input  logic              hitbody,
  input  logic              key,
  input  logic              pause_key,
  input  logic [15:0]       point,
  output logic [2:0]        status,
  output logic              die,
  output logic              restart,
  output logic              score_flag,
  output logic [LIFE_W-1:0] lives
);

  localparam int unsigned MAX_RH  = (RESTART_CYC > HOLD_CYC) ? RESTART_CYC : HOLD_CYC;
  localparam int unsigned CNT_MAX = (MAX_RH > RESPAWN_CYC) ? MAX_RH : RESPAWN_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PH_W    = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned BLK_W   = (BLINK_NUM > 0) ? $clog2(BLINK_NUM + 1) : 1;

  localparam logic [CNT_W-1:0]  RESTART_END = CNT_W'(RESTART_CYC);
  localparam logic [CNT_W-1:0]  HOLD_END    = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0]  RESPAWN_END = CNT_W'(RESPAWN_CYC - 1);
  localparam logic [PH_W-1:0]   PH_END      = PH_W'(BLINK_CYC - 1);
  localparam logic [BLK_W-1:0]  BLK_END     = BLK_W'(BLINK_NUM);
  localparam logic [LIFE_W-1:0] LIVES_INIT  = LIFE_W'(LIVES);

  typedef enum logic [2:0] {
    S_RESTART = 3'd0,
    S_START   = 3'd1,
    S_PLAY    = 3'd2,
    S_DIE     = 3'd3,
    S_PAUSE   = 3'd4,
    S_RESPAWN = 3'd5,
    S_WIN     = 3'd6,
    S_BAD     = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BLK_W-1:0]  blink_q, blink_d;
  logic              die_q, die_d;
  logic              restart_q, restart_d;
  logic              flag_q, flag_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic              key_q, pause_q;

  logic key_rise, pause_rise, hit, win_reached;

  assign key_rise    = key & ~key_q;
  assign pause_rise  = pause_key & ~pause_q;
  assign hit         = hitwall | hitbody;
  // Packed BCD orders the same way as unsigned binary, so a plain compare works.
  assign win_reached = (point >= WIN_POINT);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESTART;
      cnt_q     <= '0;
      phase_q   <= '0;
      blink_q   <= '0;
      die_q     <= 1'b1;
      restart_q <= 1'b0;
      flag_q    <= 1'b0;
      lives_q   <= LIVES_INIT;
      key_q     <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      blink_q   <= blink_d;
      die_q     <= die_d;
      restart_q <= restart_d;
      flag_q    <= flag_d;
      lives_q   <= lives_d;
      key_q     <= key;
      pause_q   <= pause_key;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESTART: if (cnt_q >= RESTART_END) state_d = S_START;
      S_START:   if (key_rise) state_d = S_PLAY;
      S_PLAY: begin
        if (hit)              state_d = (lives_q > LIFE_W'(1)) ? S_RESPAWN : S_DIE;
        else if (win_reached) state_d = S_WIN;
        else if (pause_rise)  state_d = S_PAUSE;
      end
      S_PAUSE:   if (pause_rise) state_d = S_PLAY;
      S_RESPAWN: if (cnt_q >= RESPAWN_END) state_d = S_PLAY;
      S_DIE:     if (key_rise && (cnt_q == HOLD_END)) state_d = S_RESTART;
      S_WIN:     if (key_rise) state_d = S_RESTART;
      default:   state_d = S_RESTART;
    endcase
  end

  // Next values of the counters and registered outputs.
  always_comb begin
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    blink_d   = blink_q;
    die_d     = die_q;
    lives_d   = lives_q;
    restart_d = (state_d == S_RESTART);
    flag_d    = (state_d == S_DIE) || (state_d == S_WIN);
    case (state_q)
      S_RESTART: begin
        if (state_d == S_START) begin
          cnt_d   = '0;
          lives_d = LIVES_INIT;
          die_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PLAY: begin
        if (state_d == S_RESPAWN) begin
          lives_d = lives_q - LIFE_W'(1);
          die_d   = 1'b0;
          cnt_d   = '0;
        end else if (state_d == S_DIE) begin
          lives_d = '0;
          cnt_d   = '0;
          phase_d = '0;
          blink_d = '0;
        end
      end
      S_RESPAWN: begin
        if (state_d == S_PLAY) begin
          die_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIE: begin
        if (blink_q >= BLK_END) die_d = 1'b1;
        if (state_d == S_RESTART) begin
          die_d = 1'b1;
          cnt_d = '0;
        end else if (cnt_q < HOLD_END) begin
          cnt_d = cnt_q + CNT_W'(1);
          // phase tracks cnt modulo BLINK_CYC, so a wrap marks a nonzero multiple
          if (phase_q == PH_END) begin
            phase_d = '0;
            if (blink_q < BLK_END) begin
              die_d   = ~die_q;
              blink_d = blink_q + BLK_W'(1);
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      S_WIN: begin
        die_d = 1'b1;
        if (state_d == S_RESTART) cnt_d = '0;
      end
      S_START, S_PAUSE: ;
      default: begin
        cnt_d   = '0;
        phase_d = '0;
        blink_d = '0;
        die_d   = 1'b1;
      end
    endcase
  end

  assign status     = state_q;
  assign die        = die_q;
  assign restart    = restart_q;
  assign score_flag = flag_q;
  assign lives      = lives_q;

endmodule
